mux_stim_sequencer: RTL and testbench

- Self-checking stimulus stage that drives the 2:1 mux's data and select inputs on the board.
- Steps through a fixed 8-entry vector table at a prescaled rate slow enough to watch on LEDs.
- Samples the mux output at the end of each step and compares it to the expected value.
- Reports pass/fail, an error count and a done flag to the LED/status logic downstream.

---
 rtl/mux_stim_sequencer_pkg.sv | 44 ++++
 rtl/mux_stim_sequencer_tick_prescaler.sv | 37 +++
 rtl/mux_stim_sequencer.sv | 121 ++++++++++++
 tb/tb_mux_stim_sequencer.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mux_stim_sequencer_pkg.sv
// mux_stim_sequencer_pkg
//   Shared definitions for the mux stimulus sequencer:
//   - state_e   : sequencer FSM states (IDLE=0, RUN=1, DONE=2)
//   - NUM_VEC   : number of entries in the vector table
//   - IDX_W     : width of a vector index
//   - vec_t     : one table entry {data, sel, exp}
//   - vec_lookup: index -> table entry
package mux_stim_sequencer_pkg;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StRun  = 2'd1,
        StDone = 2'd2
    } state_e;

    localparam int unsigned NUM_VEC = 8;
    localparam int unsigned IDX_W   = 3;

    typedef struct packed {
        logic [1:0] data;  // mux data inputs {in1, in0}
        logic       sel;   // mux select
        logic       exp;   // expected mux output
    } vec_t;

    // Table is written out explicitly rather than derived, so that a fault in the
    // expected column cannot hide behind the same formula the mux implements.
    function automatic vec_t vec_lookup(input logic [IDX_W-1:0] idx);
        vec_t v;
        v = '0;
        case (idx)
            3'd0:    v = '{data: 2'b00, sel: 1'b0, exp: 1'b0};
            3'd1:    v = '{data: 2'b01, sel: 1'b1, exp: 1'b0};
            3'd2:    v = '{data: 2'b10, sel: 1'b0, exp: 1'b0};
            3'd3:    v = '{data: 2'b11, sel: 1'b1, exp: 1'b1};
            3'd4:    v = '{data: 2'b00, sel: 1'b1, exp: 1'b0};
            3'd5:    v = '{data: 2'b01, sel: 1'b0, exp: 1'b1};
            3'd6:    v = '{data: 2'b10, sel: 1'b1, exp: 1'b1};
            3'd7:    v = '{data: 2'b11, sel: 1'b0, exp: 1'b1};
            default: v = '0;
        endcase
        return v;
    endfunction

endpackage

// File: rtl/mux_stim_sequencer_tick_prescaler.sv
// mux_stim_sequencer_tick_prescaler
//   Step-rate prescaler: counts enabled cycles and flags the last one of each
//   TICK_DIV-cycle period.
//   Ports:
//     clk    in  system clock
//     rst_n  in  asynchronous active-low reset (count -> 0)
//     en     in  count enable; a disabled cycle neither counts nor terminates
//     clr    in  synchronous clear, wins over en
//     tc     out terminal count: high on the enabled cycle with count == TICK_DIV-1
module mux_stim_sequencer_tick_prescaler #(
    parameter int unsigned TICK_DIV = 50_000_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic clr,
    output logic tc
);

    localparam int unsigned CntW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CntW-1:0] TermCnt = CntW'(TICK_DIV - 1);

    logic [CntW-1:0] cnt_q;

    assign tc = en && (cnt_q == TermCnt);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (clr || tc) begin
            cnt_q <= '0;
        end else if (en) begin
            cnt_q <= cnt_q + CntW'(1);
        end
    end

endmodule

// File: rtl/mux_stim_sequencer.sv
// mux_stim_sequencer
//   Steps a 2:1 mux under test through an 8-entry vector table at a prescaled
//   rate, checks mux_out at the end of each step and reports the result.
//   Ports:
//     clk        in   system clock
//     rst_n      in   asynchronous active-low reset
//     start      in   single-cycle pulse: start or restart a run
//     pause      in   level: freezes the prescaler and step advance while in RUN
//     mux_out    in   output of the mux under test
//     mux_in     out  data inputs driven to the mux
//     mux_sel    out  select driven to the mux
//     step_idx   out  index of the vector currently applied
//     expected   out  expected mux_out for the current vector
//     running    out  high in RUN
//     done       out  level in DONE (LOOP=0); 1-cycle pulse per pass (LOOP=1)
//     err_sticky out  set on any mismatch, cleared by reset or start
//     err_count  out  mismatch count, saturating at 15
module mux_stim_sequencer
    import mux_stim_sequencer_pkg::*;
#(
    parameter int unsigned TICK_DIV = 50_000_000,
    parameter bit          LOOP     = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             pause,
    input  logic             mux_out,
    output logic [1:0]       mux_in,
    output logic             mux_sel,
    output logic [IDX_W-1:0] step_idx,
    output logic             expected,
    output logic             running,
    output logic             done,
    output logic             err_sticky,
    output logic [3:0]       err_count
);

    localparam logic [IDX_W-1:0] LastIdx = IDX_W'(NUM_VEC - 1);

    state_e           state_q;
    logic             pre_en;
    logic             tick;
    logic             last_vec;
    logic [IDX_W-1:0] nxt_idx;
    vec_t             nxt_vec;

    // Prescaler only runs in RUN, so pause is naturally ignored in IDLE/DONE.
    assign pre_en = (state_q == StRun) && !pause;

    mux_stim_sequencer_tick_prescaler #(
        .TICK_DIV (TICK_DIV)
    ) u_prescaler (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (pre_en),
        .clr   (start),
        .tc    (tick)
    );

    // Index and vector that get loaded whenever the outputs move on: either a
    // (re)start or a step advance, which wraps to 0 after the last vector.
    assign last_vec = (step_idx == LastIdx);
    assign nxt_idx  = (start || last_vec) ? '0 : step_idx + IDX_W'(1);
    assign nxt_vec  = vec_lookup(nxt_idx);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            step_idx   <= '0;
            mux_in     <= '0;
            mux_sel    <= 1'b0;
            expected   <= 1'b0;
            running    <= 1'b0;
            done       <= 1'b0;
            err_sticky <= 1'b0;
            err_count  <= '0;
        end else if (start) begin
            // Start wins in every state, including a coincident terminal edge,
            // so no compare happens on this edge.
            state_q                       <= StRun;
            step_idx                      <= nxt_idx;
            {mux_in, mux_sel, expected}   <= nxt_vec;
            running                       <= 1'b1;
            done                          <= 1'b0;
            err_sticky                    <= 1'b0;
            err_count                     <= '0;
        end else begin
            case (state_q)
                StRun: begin
                    done <= 1'b0;
                    if (tick) begin
                        // mux_out has had TICK_DIV-1 cycles to settle here.
                        if (mux_out != expected) begin
                            err_sticky <= 1'b1;
                            if (err_count != 4'hf) begin
                                err_count <= err_count + 4'd1;
                            end
                        end
                        if (last_vec && !LOOP) begin
                            // Stop with vector 7 still applied.
                            state_q <= StDone;
                            running <= 1'b0;
                            done    <= 1'b1;
                        end else begin
                            step_idx                    <= nxt_idx;
                            {mux_in, mux_sel, expected} <= nxt_vec;
                            if (last_vec) begin
                                done <= 1'b1;
                            end
                        end
                    end
                end
                default: begin
                    // IDLE and DONE hold every output until start.
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mux_stim_sequencer.sv
// tb_mux_stim_sequencer
//   Two sequencers (LOOP=0 and LOOP=1, TICK_DIV=4) driving a modelled mux that
//   can be ideal, stuck-at-0 or stuck-at-1. A per-cycle behavioural model
//   predicts every output; directed scenarios plus a randomized phase.
module tb_mux_stim_sequencer;

    localparam int TICK = 4;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic       pause;
    int         fault_mode;  // 0 ideal, 1 stuck-at-0, 2 stuck-at-1

    logic [1:0] mux_in0, mux_in1;
    logic       mux_sel0, mux_sel1;
    logic [2:0] step_idx0, step_idx1;
    logic       expected0, expected1;
    logic       running0, running1;
    logic       done0, done1;
    logic       err_sticky0, err_sticky1;
    logic [3:0] err_count0, err_count1;
    logic       mux_out0, mux_out1;
    logic [13:0] pack0, pack1;

    int n_checks;
    int n_fail;
    int cyc;
    int done1_seen;

    // Reference table: {mux_in, mux_sel}; expected follows from the mux rule.
    int tbl_in[8]  = '{0, 1, 2, 3, 0, 1, 2, 3};
    int tbl_sel[8] = '{0, 1, 0, 1, 1, 0, 1, 0};

    // Model state, one slot per DUT (slot 1 is the looping one).
    bit m_run[2];
    bit m_fin[2];
    bit m_pulse[2];
    int m_idx[2];
    int m_el[2];
    int m_err[2];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic bit mux_model(int data, int sel);
        if (fault_mode == 1) return 1'b0;
        if (fault_mode == 2) return 1'b1;
        return bit'(sel != 0 ? (data >> 1) & 1 : data & 1);
    endfunction

    assign mux_out0 = mux_model(int'(mux_in0), int'(mux_sel0));
    assign mux_out1 = mux_model(int'(mux_in1), int'(mux_sel1));

    assign pack0 = {mux_in0, mux_sel0, step_idx0, expected0, running0, done0,
                    err_sticky0, err_count0};
    assign pack1 = {mux_in1, mux_sel1, step_idx1, expected1, running1, done1,
                    err_sticky1, err_count1};

    mux_stim_sequencer #(.TICK_DIV(TICK), .LOOP(1'b0)) u_dut0 (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .pause      (pause),
        .mux_out    (mux_out0),
        .mux_in     (mux_in0),
        .mux_sel    (mux_sel0),
        .step_idx   (step_idx0),
        .expected   (expected0),
        .running    (running0),
        .done       (done0),
        .err_sticky (err_sticky0),
        .err_count  (err_count0)
    );

    mux_stim_sequencer #(.TICK_DIV(TICK), .LOOP(1'b1)) u_dut1 (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .pause      (pause),
        .mux_out    (mux_out1),
        .mux_in     (mux_in1),
        .mux_sel    (mux_sel1),
        .step_idx   (step_idx1),
        .expected   (expected1),
        .running    (running1),
        .done       (done1),
        .err_sticky (err_sticky1),
        .err_count  (err_count1)
    );

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s cycle %0d: got 0x%0h, expected 0x%0h", tag, cyc, got, exp);
        end
    endtask

    function automatic bit exp_of(int v);
        return bit'(tbl_sel[v] != 0 ? (tbl_in[v] >> 1) & 1 : tbl_in[v] & 1);
    endfunction

    function automatic logic [13:0] model_out(int i);
        int v;
        int din;
        int sel;
        int cnt;
        v   = m_idx[i];
        din = tbl_in[v];
        sel = tbl_sel[v];
        cnt = (m_err[i] > 15) ? 15 : m_err[i];
        return {din[1:0], sel[0], v[2:0], exp_of(v), m_run[i], m_fin[i] | m_pulse[i],
                m_err[i] != 0, cnt[3:0]};
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_run[i] = 0; m_fin[i] = 0; m_pulse[i] = 0;
            m_idx[i] = 0; m_el[i] = 0; m_err[i] = 0;
        end
    endtask

    // One clock edge of the model: start restarts; otherwise each unpaused RUN
    // cycle counts toward the step length and the last one compares and advances.
    task automatic model_step(input int i, input bit st, input bit ps, input bit mo);
        if (st) begin
            m_run[i] = 1; m_fin[i] = 0; m_pulse[i] = 0;
            m_idx[i] = 0; m_el[i] = 0; m_err[i] = 0;
            return;
        end
        m_pulse[i] = 0;
        if (m_run[i] && !ps) begin
            m_el[i]++;
            if (m_el[i] == TICK) begin
                m_el[i] = 0;
                if (mo != exp_of(m_idx[i])) m_err[i]++;
                if (m_idx[i] == 7) begin
                    if (i == 1) begin
                        m_idx[i] = 0;
                        m_pulse[i] = 1;
                    end else begin
                        m_run[i] = 0;
                        m_fin[i] = 1;
                    end
                end else begin
                    m_idx[i]++;
                end
            end
        end
    endtask

    // Called at a negedge: compare, drive inputs, advance one clock.
    task automatic tick(input bit st, input bit ps);
        bit mo[2];
        cyc++;
        check("dut0_outputs", int'(pack0), int'(model_out(0)));
        check("dut1_outputs", int'(pack1), int'(model_out(1)));
        if (done1) done1_seen++;
        start = st;
        pause = ps;
        for (int i = 0; i < 2; i++) begin
            mo[i] = mux_model(tbl_in[m_idx[i]], tbl_sel[m_idx[i]]);
        end
        @(posedge clk);
        for (int i = 0; i < 2; i++) model_step(i, st, ps, mo[i]);
        @(negedge clk);
    endtask

    initial begin
        int idx2_len;
        int pcnt;
        int guard;
        n_checks = 0; n_fail = 0; cyc = 0; done1_seen = 0;
        rst_n = 1'b0; start = 1'b0; pause = 1'b0; fault_mode = 0;
        model_reset();

        // Reset state with start low.
        @(negedge clk);
        @(negedge clk);
        check("reset_dut0", int'(pack0), 0);
        check("reset_dut1", int'(pack1), 0);
        rst_n = 1'b1;
        repeat (3) tick(1'b0, 1'b0);

        // Full pass with an ideal mux.
        tick(1'b1, 1'b0);
        repeat (40) tick(1'b0, 1'b0);
        check("pass_done", int'(done0), 1);
        check("pass_err_count", int'(err_count0), 0);
        check("pass_final_idx", int'(step_idx0), 7);

        // Stuck-at-0 mux: vectors 3,5,6,7 mismatch.
        fault_mode = 1;
        tick(1'b1, 1'b0);
        repeat (40) tick(1'b0, 1'b0);
        check("stuck0_err_count", int'(err_count0), 4);
        check("stuck0_sticky", int'(err_sticky0), 1);

        // Pause 10 cycles at the start of idx 2.
        fault_mode = 0;
        tick(1'b1, 1'b0);
        pcnt = 0; idx2_len = 0;
        repeat (60) begin
            bit ps;
            if (step_idx0 == 3'd2 && running0) idx2_len++;
            ps = (m_idx[0] == 2 && pcnt < 10);
            if (ps) pcnt++;
            tick(1'b0, ps);
        end
        check("pause_idx2_len", idx2_len, 14);
        check("pause_err_count", int'(err_count0), 0);
        check("pause_done", int'(done0), 1);

        // Looping DUT with stuck-at-1 over 5 passes.
        fault_mode = 2;
        tick(1'b1, 1'b0);
        done1_seen = 0;
        repeat (162) tick(1'b0, 1'b0);
        check("loop_done_pulses", done1_seen, 5);
        check("loop_err_sat", int'(err_count1), 15);
        tick(1'b1, 1'b0);
        tick(1'b0, 1'b0);
        check("loop_restart_clear", int'(err_count1), 0);

        // Asynchronous reset mid-step at idx 4.
        fault_mode = 0;
        tick(1'b1, 1'b0);
        guard = 0;
        while (!(m_idx[0] == 4 && m_el[0] == 1) && guard < 100) begin
            tick(1'b0, 1'b0);
            guard++;
        end
        check("reach_idx4", int'(step_idx0), 4);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_dut0", int'(pack0), 0);
        check("async_rst_dut1", int'(pack1), 0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        repeat (10) tick(1'b0, 1'b0);
        check("idle_after_rst", int'(running0), 0);

        // Randomized phase: random pause, occasional start, changing fault.
        for (int n = 0; n < 2000; n++) begin
            if (n % 300 == 0) fault_mode = int'($urandom_range(0, 2));
            tick($urandom_range(0, 63) == 0, $urandom_range(0, 3) == 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
